// File: rtl/load_store_unit.sv
// Load/store unit: single-transaction bus master with byte-lane formatting and a bus timeout.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of masking the low bits.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  alucode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] load_data,
    output logic [4:0]  rd_out,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    // state | meaning
    // IDLE  | waiting for an operation, req_ready=1
    // BUS   | mem_req held until mem_ack or timeout
    // RESP  | response presented until resp_ready
    localparam logic [5:0] ALU_LB  = 6'd23;
    localparam logic [5:0] ALU_LH  = 6'd24;
    localparam logic [5:0] ALU_LW  = 6'd25;
    localparam logic [5:0] ALU_LBU = 6'd26;
    localparam logic [5:0] ALU_LHU = 6'd27;
    localparam logic [5:0] ALU_SB  = 6'd28;
    localparam logic [5:0] ALU_SH  = 6'd29;
    localparam logic [5:0] ALU_SW  = 6'd30;

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t        state, state_nxt;
    logic [5:0]    op_q;
    logic [31:0]   addr_q;
    logic [31:0]   sdata_q;
    logic [4:0]    rd_q;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   ld_q;
    logic          mis_q;
    logic          berr_q;
    logic          accept;
    logic          trap_in;
    logic          timeout;

    function automatic logic is_mem(input logic [5:0] code);
        return (code >= ALU_LB) && (code <= ALU_SW);
    endfunction

    function automatic logic misaligned(input logic [5:0] code, input logic [1:0] a);
        logic half, word;
        half = (code == ALU_LH) || (code == ALU_LHU) || (code == ALU_SH);
        word = (code == ALU_LW) || (code == ALU_SW);
        return (half && a[0]) || (word && (a != 2'b00));
    endfunction

    function automatic logic [31:0] fmt_load(input logic [5:0] code, input logic [1:0] a,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{a, 3'b000} +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (code)
            ALU_LB:  return {{24{b[7]}}, b};
            ALU_LBU: return {24'd0, b};
            ALU_LH:  return {{16{h[15]}}, h};
            ALU_LHU: return {16'd0, h};
            ALU_LW:  return d;
            default: return 32'd0;
        endcase
    endfunction

    assign accept = req_valid && (state == IDLE);
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_in = misaligned(alucode, addr[1:0]);
`else
    assign trap_in = 1'b0;
`endif
    assign timeout = (state == BUS) && !mem_ack && (wait_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = (is_mem(alucode) && !trap_in) ? BUS : RESP;
            BUS:  if (mem_ack || wait_cnt == '0) state_nxt = RESP;
            RESP: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            addr_q   <= '0;
            sdata_q  <= '0;
            rd_q     <= '0;
            wait_cnt <= '0;
            ld_q     <= '0;
            mis_q    <= 1'b0;
            berr_q   <= 1'b0;
        end else if (accept) begin
            op_q     <= alucode;
            addr_q   <= addr;
            sdata_q  <= store_data;
            rd_q     <= rd_in;
            wait_cnt <= WAIT_LOAD;
            ld_q     <= '0;
            mis_q    <= trap_in;
            berr_q   <= 1'b0;
        end else if (state == BUS) begin
            // ack beats a same-cycle timeout
            if (mem_ack) begin
                ld_q   <= fmt_load(op_q, addr_q[1:0], mem_rdata);
                berr_q <= 1'b0;
            end else if (timeout) begin
                ld_q   <= '0;
                berr_q <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        logic in_bus;
        in_bus       = (state == BUS);
        req_ready    = (state == IDLE);
        resp_valid   = (state == RESP);
        load_data    = ld_q;
        rd_out       = rd_q;
        misalign_err = mis_q;
        bus_err      = berr_q;
        mem_req      = in_bus;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wstrb    = 4'b0000;
        mem_wdata    = '0;
        if (in_bus) begin
            mem_addr = {addr_q[31:2], 2'b00};
            case (op_q)
                ALU_SB: begin
                    mem_we    = 1'b1;
                    mem_wstrb = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{sdata_q[7:0]}};
                end
                ALU_SH: begin
                    mem_we    = 1'b1;
                    mem_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
                    mem_wdata = {2{sdata_q[15:0]}};
                end
                ALU_SW: begin
                    mem_we    = 1'b1;
                    mem_wstrb = 4'b1111;
                    mem_wdata = sdata_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected bus transactions and responses are queued
// at issue time and compared by independent bus and response monitors.
module tb_load_store_unit;
    localparam logic [5:0] ALU_ADD = 6'd1;
    localparam logic [5:0] ALU_LB  = 6'd23;
    localparam logic [5:0] ALU_LH  = 6'd24;
    localparam logic [5:0] ALU_LW  = 6'd25;
    localparam logic [5:0] ALU_LBU = 6'd26;
    localparam logic [5:0] ALU_LHU = 6'd27;
    localparam logic [5:0] ALU_SB  = 6'd28;
    localparam logic [5:0] ALU_SH  = 6'd29;
    localparam logic [5:0] ALU_SW  = 6'd30;

    typedef struct {
        logic [31:0] ld;
        logic [4:0]  rd;
        logic        mis;
        logic        berr;
    } resp_t;

    typedef struct {
        logic [31:0] maddr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          len;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [5:0]  alucode;
    logic [31:0] addr, store_data;
    logic [4:0]  rd_in, rd_out;
    logic        resp_valid, resp_ready;
    logic [31:0] load_data;
    logic        misalign_err, bus_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int    checks = 0;
    int    errors = 0;
    resp_t resp_q[$];
    bus_t  bus_q[$];
    int    ack_at = 0;
    int    bus_cnt = 0;
    bit    spurious = 1'b0;
    logic [31:0] rdata_v = 32'd0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .alucode(alucode), .addr(addr), .store_data(store_data), .rd_in(rd_in),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .load_data(load_data), .rd_out(rd_out),
        .misalign_err(misalign_err), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // memory responder: ack on BUS cycle ack_at (0 = never)
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            bus_cnt++;
            mem_ack   = (ack_at != 0) && (bus_cnt == ack_at);
            mem_rdata = mem_ack ? rdata_v : 32'hDEAD_DEAD;
        end else begin
            bus_cnt   = 0;
            mem_ack   = spurious;
            mem_rdata = ~rdata_v;
        end
    end

    bus_t        cur;
    int          blen = 0;
    bit          prev_req = 1'b0;
    logic [68:0] held;

    always @(negedge clk) begin
        if (mem_req) begin
            if (!prev_req) begin
                blen = 1;
                checks++;
                if (bus_q.size() == 0) begin
                    errors++;
                    cur.len = 0;
                    $display("FAIL bus_unexpected: mem_req=1 addr=%h, required no request", mem_addr);
                end else begin
                    cur = bus_q.pop_front();
                    if (mem_addr !== cur.maddr || mem_we !== cur.we || mem_wstrb !== cur.strb ||
                        (cur.we && mem_wdata !== cur.wdata)) begin
                        errors++;
                        $display("FAIL bus_fields: got addr=%h we=%b strb=%b wdata=%h, required addr=%h we=%b strb=%b wdata=%h",
                                 mem_addr, mem_we, mem_wstrb, mem_wdata, cur.maddr, cur.we, cur.strb, cur.wdata);
                    end
                end
            end else begin
                blen++;
                checks++;
                if ({mem_addr, mem_we, mem_wstrb, mem_wdata} !== held) begin
                    errors++;
                    $display("FAIL bus_stable: got %h, required %h", {mem_addr, mem_we, mem_wstrb, mem_wdata}, held);
                end
            end
            held = {mem_addr, mem_we, mem_wstrb, mem_wdata};
        end else if (prev_req) begin
            checks++;
            if (blen != cur.len) begin
                errors++;
                $display("FAIL bus_len: got %0d cycles, required %0d", blen, cur.len);
            end
        end
        prev_req = mem_req;
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && resp_valid && resp_ready) begin
            checks++;
            if (resp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got rd=%0d data=%h, required no response", rd_out, load_data);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                if (load_data !== e.ld || rd_out !== e.rd || misalign_err !== e.mis || bus_err !== e.berr) begin
                    errors++;
                    $display("FAIL resp_fields: got data=%h rd=%0d mis=%b berr=%b, required data=%h rd=%0d mis=%b berr=%b",
                             load_data, rd_out, misalign_err, bus_err, e.ld, e.rd, e.mis, e.berr);
                end
            end
        end
    end

    task automatic run_op(input logic [5:0] code, input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] rd, input logic [31:0] rdata, input int ackat,
                          input bit has_bus, input logic [31:0] e_maddr, input logic e_we,
                          input logic [3:0] e_strb, input logic [31:0] e_wdata, input int e_len,
                          input logic [31:0] e_ld, input logic e_mis, input logic e_berr,
                          input int e_lat, input int stall);
        int lat;
        logic [31:0] snap_ld;
        logic [4:0]  snap_rd;
        ack_at  = ackat;
        rdata_v = rdata;
        if (has_bus) bus_q.push_back('{e_maddr, e_we, e_strb, e_wdata, e_len});
        resp_q.push_back('{e_ld, rd, e_mis, e_berr});
        resp_ready = (stall == 0);
        req_valid  = 1'b1;
        alucode    = code;
        addr       = a;
        store_data = sd;
        rd_in      = rd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        alucode    = 6'h3F;
        addr       = 32'hFFFF_FFFF;
        store_data = 32'h5555_5555;
        rd_in      = 5'h1F;
        lat = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp_valid) break;
            lat++;
            @(posedge clk);
        end
        checks++;
        if (!resp_valid) begin
            errors++;
            $display("FAIL resp_wait: resp_valid=0 after %0d cycles, required 1", lat);
        end else if (e_lat > 0 && lat != e_lat) begin
            errors++;
            $display("FAIL resp_latency: got %0d cycles, required %0d", lat, e_lat);
        end
        if (stall > 0) begin
            snap_ld = load_data;
            snap_rd = rd_out;
            for (int i = 0; i < stall; i++) begin
                checks++;
                if (!resp_valid || req_ready || load_data !== snap_ld || rd_out !== snap_rd) begin
                    errors++;
                    $display("FAIL resp_hold: got valid=%b ready=%b data=%h rd=%0d, required valid=1 ready=0 data=%h rd=%0d",
                             resp_valid, req_ready, load_data, rd_out, snap_ld, snap_rd);
                end
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            resp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 20 && !req_ready; k++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL return_idle: req_ready=%b, required 1", req_ready);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        alucode    = 6'd0;
        addr       = 32'd0;
        store_data = 32'd0;
        rd_in      = 5'd0;
        resp_ready = 1'b1;
        #2;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
            mem_addr !== 32'd0 || mem_wstrb !== 4'd0 || mem_wdata !== 32'd0 || load_data !== 32'd0 ||
            rd_out !== 5'd0 || misalign_err !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b rvalid=%b req=%b we=%b addr=%h strb=%b ld=%h rd=%0d, required ready=1 rest 0",
                     req_ready, resp_valid, mem_req, mem_we, mem_addr, mem_wstrb, load_data, rd_out);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(ALU_LB,  32'h0000_0103, 32'd0, 5'd1, 32'h80FF_1234, 1, 1, 32'h100, 0, 4'b0000, 0, 1, 32'hFFFF_FF80, 0, 0, 2, 0);
        run_op(ALU_LBU, 32'h0000_0101, 32'd0, 5'd2, 32'h1234_A578, 2, 1, 32'h100, 0, 4'b0000, 0, 2, 32'h0000_00A5, 0, 0, 3, 0);
        run_op(ALU_LH,  32'h0000_0202, 32'd0, 5'd3, 32'h8001_7FFF, 1, 1, 32'h200, 0, 4'b0000, 0, 1, 32'hFFFF_8001, 0, 0, 2, 0);
        run_op(ALU_LHU, 32'h0000_0200, 32'd0, 5'd4, 32'h8001_9ABC, 1, 1, 32'h200, 0, 4'b0000, 0, 1, 32'h0000_9ABC, 0, 0, 2, 0);
        run_op(ALU_LW,  32'h0000_0300, 32'd0, 5'd5, 32'hCAFE_F00D, 3, 1, 32'h300, 0, 4'b0000, 0, 3, 32'hCAFE_F00D, 0, 0, 4, 0);
        run_op(ALU_SH,  32'h0000_0202, 32'hDEAD_BEEF, 5'd6, 32'h1111_1111, 1, 1, 32'h200, 1, 4'b1100, 32'hBEEF_BEEF, 1, 32'd0, 0, 0, 2, 0);
        run_op(ALU_SB,  32'h0000_0401, 32'h1234_5678, 5'd7, 32'h2222_2222, 2, 1, 32'h400, 1, 4'b0010, 32'h7878_7878, 2, 32'd0, 0, 0, 3, 0);
        run_op(ALU_SW,  32'h0000_0500, 32'hA5A5_0F0F, 5'd8, 32'h3333_3333, 1, 1, 32'h500, 1, 4'b1111, 32'hA5A5_0F0F, 1, 32'd0, 0, 0, 2, 0);
        spurious = 1'b1;
        run_op(ALU_ADD, 32'h0000_0104, 32'h0000_0001, 5'd9, 32'h4444_4444, 1, 0, 0, 0, 4'b0000, 0, 0, 32'd0, 0, 0, 1, 0);
        spurious = 1'b0;
        run_op(ALU_LW,  32'h0000_0600, 32'd0, 5'd10, 32'h5555_5555, 0, 1, 32'h600, 0, 4'b0000, 0, 4, 32'd0, 0, 1, 5, 0);
        run_op(ALU_LW,  32'h0000_0600, 32'd0, 5'd11, 32'h1122_3344, 4, 1, 32'h600, 0, 4'b0000, 0, 4, 32'h1122_3344, 0, 0, 5, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        run_op(ALU_LW,  32'h0000_0101, 32'd0, 5'd12, 32'h0BAD_F00D, 1, 0, 0, 0, 4'b0000, 0, 0, 32'd0, 1, 0, 1, 0);
        run_op(ALU_LH,  32'h0000_0203, 32'd0, 5'd13, 32'h7F00_1111, 1, 0, 0, 0, 4'b0000, 0, 0, 32'd0, 1, 0, 1, 0);
`else
        run_op(ALU_LW,  32'h0000_0101, 32'd0, 5'd12, 32'h0BAD_F00D, 1, 1, 32'h100, 0, 4'b0000, 0, 1, 32'h0BAD_F00D, 0, 0, 2, 0);
        run_op(ALU_LH,  32'h0000_0203, 32'd0, 5'd13, 32'h7F00_1111, 1, 1, 32'h200, 0, 4'b0000, 0, 1, 32'h0000_7F00, 0, 0, 2, 0);
`endif
        run_op(ALU_LHU, 32'h0000_0002, 32'd0, 5'd14, 32'hBEEF_0000, 1, 1, 32'h000, 0, 4'b0000, 0, 1, 32'h0000_BEEF, 0, 0, 2, 5);

        // reset while the bus request is outstanding
        ack_at = 0;
        bus_q.push_back('{32'h700, 1'b0, 4'b0000, 32'd0, 2});
        req_valid = 1'b1;
        alucode   = ALU_LW;
        addr      = 32'h0000_0700;
        rd_in     = 5'd15;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_bus: got req=%b ready=%b rvalid=%b, required 0 1 0", mem_req, req_ready, resp_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_quiet: got rvalid=%b req=%b, required 0 0", resp_valid, mem_req);
            end
        end
        @(posedge clk);
        #1;
        run_op(ALU_LB,  32'h0000_0000, 32'd0, 5'd16, 32'h0000_00FE, 1, 1, 32'h000, 0, 4'b0000, 0, 1, 32'hFFFF_FFFE, 0, 0, 2, 0);

        repeat (3) @(posedge clk);
        checks++;
        if (resp_q.size() != 0 || bus_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d responses and %0d bus transfers outstanding, required 0 and 0",
                     resp_q.size(), bus_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles mem_req is held without mem_ack before abort.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports clk, rst_n.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  execute stage presents an operation.
REQ-006 req_ready  output  1  unit can accept an operation.
REQ-007 alucode  input  6  operation code using the ALU_* encodings from define.vh.
REQ-008 addr  input  32  effective address, which is the ALU result.
REQ-009 store_data  input  32  rs2 value for stores.
REQ-010 rd_in  input  5  destination register index.
REQ-011 resp_valid / resp_ready  output / input  1 / 1  response handshake to writeback.
REQ-012 load_data  output  32  formatted load result; 0 for stores and non-memory codes.
REQ-013 rd_out  output  5  latched rd_in.
REQ-014 misalign_err, bus_err  output  1 each  response error flags.
REQ-015 mem_req, mem_we  output  1 each  bus request and write enable.
REQ-016 mem_addr  output  32  word address with bits [1:0] equal to 0.
REQ-017 mem_wstrb  output  4  byte write strobes.
REQ-018 mem_wdata  output  32  lane-aligned write data.
REQ-019 mem_ack, mem_rdata  input  1 / 32  bus completion and read data.

Function
REQ-020 SHALL implement FSM states IDLE, BUS and RESP; req_ready = (state==IDLE).
REQ-021 In IDLE, when req_valid&&req_ready, SHALL latch alucode, addr, store_data and rd_in.
REQ-022 After the IDLE accept: a memory code goes to BUS; any other code goes to RESP with load_data=0, no bus access and no error.
REQ-023 In BUS, mem_req SHALL be 1 and all mem_* outputs SHALL be stable until mem_ack.
REQ-024 mem_ack SHALL be ignored while mem_req=0.
REQ-025 On mem_ack, SHALL capture and format mem_rdata, then go to RESP; minimum accept-to-resp_valid latency is 2 cycles (ack in first BUS cycle).
REQ-026 In RESP, resp_valid SHALL be 1 with outputs held until resp_ready; then go to IDLE; no new accept in the same cycle.
REQ-027 Loads SHALL drive mem_we=0 and mem_wstrb=0000.
REQ-028 LB/LBU SHALL select byte addr[1:0] and sign-/zero-extend it; LH/LHU SHALL select half addr[1] and sign-/zero-extend it; LW SHALL pass the full word.
REQ-029 SB SHALL drive mem_wstrb=0001<<addr[1:0] and mem_wdata={4{store_data[7:0]}}.
REQ-030 SH SHALL drive mem_wstrb=0011<<{addr[1],1'b0} and mem_wdata={2{store_data[15:0]}}.
REQ-031 SW SHALL drive mem_wstrb=1111 and mem_wdata=store_data.
REQ-032 A wait counter SHALL count BUS cycles; if TIMEOUT_CYCLES elapse without ack, SHALL drop mem_req, go to RESP with bus_err=1 and load_data=0.
REQ-033 mem_ack in the same cycle as timeout expiry SHALL win: normal completion, bus_err=0.
REQ-034 Stores SHALL produce a response with load_data=0.

Reset
REQ-035 rst_n low SHALL immediately force state=IDLE, req_ready=1, and all other outputs and the wait counter to 0.
REQ-036 Reset during BUS or RESP SHALL abandon the transaction; no response is issued after reset.

Configuration
REQ-037 Macro LSU_MISALIGN_TRAP_EN defined: a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL skip BUS and go to RESP with misalign_err=1, load_data=0 and no mem_req.
REQ-038 Macro LSU_MISALIGN_TRAP_EN undefined: the offending low address bits SHALL be treated as 0, the access SHALL proceed, and misalign_err SHALL stay 0.

Verification
REQ-039 LB addr=0x103, rdata=0x80FF_1234, ack on first BUS cycle -> load_data=0xFFFF_FF80, resp_valid 2 cycles after accept.
REQ-040 SH addr=0x202, store_data=0xDEAD_BEEF -> mem_addr=0x200, mem_wstrb=1100, mem_wdata=0xBEEF_BEEF, mem_we=1.
REQ-041 LW with mem_ack never asserted, TIMEOUT_CYCLES=4 -> mem_req drops after 4 BUS cycles, bus_err=1; ack on the 4th cycle instead -> bus_err=0.
REQ-042 LW addr=0x101 -> with the macro: misalign_err=1, mem_req never 1; without the macro: mem_addr=0x100, normal load.
REQ-043 resp_ready held 0 for 5 cycles -> load_data, rd_out and resp_valid stable, req_ready=0 throughout.
REQ-044 rst_n pulsed low during BUS -> mem_req=0 immediately, req_ready=1, no response after reset release.
